// File: rtl/unidade_busca_pkg.sv
// ============================================================================
// Module   : unidade_busca_pkg
// Purpose  : Shared definitions for the fetch unit: FSM state encodings,
//            halt-cause codes, default reset PC and an alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package unidade_busca_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HC_NONE     = 2'b00,
    HC_RANGE    = 2'b01,
    HC_MISALIGN = 2'b10
  } halt_cause_t;

  localparam logic [31:0] C_RESET_PC_DEFAULT = 32'h0000_0000;

  // Byte targets must be word aligned; only the two low bits matter.
  function automatic logic is_misaligned(input logic [1:0] i_low_bits);
    return (i_low_bits != 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/registrador_if_id.sv
// ============================================================================
// Module   : registrador_if_id
// Purpose  : IF/ID pipeline register holding instruction, byte PC and valid.
// Ports    : clk, reset (async, active-high)
//            i_clear   - drop valid (instr/pc keep their value)
//            i_capture - load i_instr / i_pc / i_valid
//            i_instr, i_pc, i_valid - values to capture
//            o_instr, o_pc, o_valid - register contents
// Notes    : i_clear has priority over i_capture; with neither asserted the
//            register holds, which is how the fetch unit implements stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module registrador_if_id #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clear,
  input  logic            i_capture,
  input  logic [BITS-1:0] i_instr,
  input  logic [31:0]     i_pc,
  input  logic            i_valid,
  output logic [BITS-1:0] o_instr,
  output logic [31:0]     o_pc,
  output logic            o_valid
);

  logic [BITS-1:0] r_instr;
  logic [31:0]     r_pc;
  logic            r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= i_valid;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/unidade_busca.sv
// ============================================================================
// Module   : unidade_busca
// Purpose  : Instruction fetch unit: PC register, BOOT/RUN/HALT control and
//            IF/ID capture against a combinational instruction memory.
// Ports    : clk, reset (async, active-high)
//            stall, flush, redirect, redirect_pc - pipeline control inputs
//            imem_addr (out) / imem_data (in)    - instruction memory port
//            id_instr, id_pc, id_valid           - IF/ID register outputs
//            halted, halt_cause                  - fetch-stopped status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter int          BITS        = 32,
  parameter int          DEPTH       = 2000,
  parameter int          i_addr_bits = 13,
  parameter logic [31:0] RESET_PC    = C_RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [i_addr_bits-3:0] imem_addr,
  input  logic [BITS-1:0]        imem_data,
  output logic [BITS-1:0]        id_instr,
  output logic [31:0]            id_pc,
  output logic                   id_valid,
  output logic                   halted,
  output logic [1:0]             halt_cause
);

  localparam logic [31:0] C_PC_LIMIT = 32'(4 * DEPTH);

  state_t      r_state;
  halt_cause_t r_halt_cause;
  logic [31:0] r_pc;
  logic        r_halted;

  logic w_misalign;
  logic w_out_of_range;
  logic w_capture;
  logic w_clear;
  logic w_valid_in;

  assign w_misalign     = redirect && is_misaligned(redirect_pc[1:0]);
  // Compared on the full 32-bit PC so the check happens before any wrap.
  assign w_out_of_range = (r_pc >= C_PC_LIMIT);

  // IF/ID control; priority mirrors the PC/FSM update below.
  always_comb begin
    w_capture  = 1'b0;
    w_clear    = 1'b0;
    w_valid_in = 1'b0;
    if (r_state == ST_RUN) begin
      if (redirect || w_out_of_range) begin
        w_clear = 1'b1;
      end else if (stall) begin
        w_clear = flush;
      end else begin
        w_capture  = 1'b1;
        w_valid_in = ~flush;
      end
    end else begin
      w_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_halted     <= 1'b0;
      r_halt_cause <= HC_NONE;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_misalign) begin
            r_state      <= ST_HALT;
            r_halted     <= 1'b1;
            r_halt_cause <= HC_MISALIGN;
          end else if (redirect) begin
            r_pc <= redirect_pc;
          end else if (w_out_of_range) begin
            r_state      <= ST_HALT;
            r_halted     <= 1'b1;
            r_halt_cause <= HC_RANGE;
          end else if (!stall) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  registrador_if_id #(
    .BITS (BITS)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_capture (w_capture),
    .i_instr   (imem_data),
    .i_pc      (r_pc),
    .i_valid   (w_valid_in),
    .o_instr   (id_instr),
    .o_pc      (id_pc),
    .o_valid   (id_valid)
  );

  assign imem_addr  = r_pc[i_addr_bits-1:2];
  assign halted     = r_halted;
  assign halt_cause = r_halt_cause;

endmodule

`default_nettype wire

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 The block SHALL have parameter BITS, default 32, meaning instruction width.
REQ-002 The block SHALL have parameter DEPTH, default 2000, meaning instruction-memory size in words.
REQ-003 The block SHALL have parameter i_addr_bits, default 13, meaning byte-address width; it equals the value given to the instruction memory.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address in bytes.
REQ-005 The block SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-006 The block SHALL have these ports:
- clk  in  1  clock, rising edge
- reset  in  1  async active-high reset
- stall  in  1  hold PC and IF/ID
- flush  in  1  invalidate IF/ID
- redirect  in  1  load redirect_pc (branch/jump)
- redirect_pc  in  32  byte target
- imem_addr  out  i_addr_bits-2  word index to memory
- imem_data  in  BITS  combinational memory read data
- id_instr  out  BITS  IF/ID instruction
- id_pc  out  32  IF/ID byte PC
- id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch stopped
- halt_cause  out  2  00 none, 01 PC out of range, 10 misaligned redirect

Function
REQ-007 imem_addr SHALL equal pc[i_addr_bits-1:2] combinationally, in every state.
REQ-008 States SHALL be BOOT, RUN and HALT; reset enters BOOT.
REQ-009 BOOT SHALL last exactly one clock: no capture, PC unchanged, id_valid 0; next state RUN.
REQ-010 In RUN, priority per edge SHALL be: misaligned redirect > redirect > out-of-range > stall > normal fetch.
REQ-011 Redirect with redirect_pc[1:0]!=0 -> HALT, halt_cause 10, pc unchanged, id_valid 0.
REQ-012 Aligned redirect -> pc<=redirect_pc, id_valid<=0; it overrides stall in the same cycle.
REQ-013 pc >= 4*DEPTH with no redirect -> HALT, halt_cause 01, no capture, id_valid 0.
REQ-014 Stall without redirect -> pc, id_instr, id_pc and id_valid hold; if flush is also high, id_valid<=0.
REQ-015 Normal fetch -> id_instr<=imem_data, id_pc<=pc, id_valid<=~flush, pc<=pc+4.
REQ-016 Fetch latency SHALL be 1 cycle: the instruction at pc appears on id_instr after the next rising edge.
REQ-017 PC arithmetic SHALL be 32-bit modulo 2^32; the range check in REQ-013 precedes any wrap.
REQ-018 HALT SHALL be left only by reset; it SHALL ignore redirect, stall and flush; pc frozen; id_valid 0; halted 1.
REQ-019 halted SHALL be 1 exactly when the state is HALT; halt_cause SHALL hold its value until reset.

Reset
REQ-020 Asserting reset at any time, including mid-stall or in HALT, SHALL immediately set pc=RESET_PC, id_instr=0, id_pc=0, id_valid=0, halted=0, halt_cause=00 and state=BOOT.
REQ-021 Release of reset SHALL follow the BOOT sequence; the first id_valid=1 SHALL appear after the second rising edge following release.

Structure
REQ-022 State encodings, halt_cause codes and the RESET_PC default SHALL live in a shared include file used by the pipeline control.
REQ-023 The IF/ID capture register (instr, pc, valid, with hold/clear inputs) SHALL be one sub-module, registrador_if_id; PC logic and the FSM SHALL stay in unidade_busca.

Verification
REQ-024 Reset released, memory words 0..2 preloaded -> id_pc sequence 0,4,8 with id_valid=1 from the second edge on, and id_instr matching each word.
REQ-025 stall high for 3 cycles while id_pc=8 -> id_pc stays 8, imem_addr stays 3, then resumes with 12.
REQ-026 redirect=1 with redirect_pc=0x28 together with stall=1 -> next id_valid=0, then id_pc=0x28 on the following edge.
REQ-027 redirect_pc=0x2A -> halted=1, halt_cause=10, pc frozen; a later redirect to 0x0 is ignored; reset clears to BOOT.
REQ-028 Redirect to 0x1F3C (DEPTH=2000) -> one valid fetch at 0x1F3C, then pc=0x1F40 -> HALT, halt_cause=01, id_valid=0.
REQ-029 flush=1 on a normal fetch at pc=0x10 -> id_valid=0 and pc=0x14 on that edge; reset asserted mid-run -> all outputs zero without a clock edge.
